des_ip_stage1: RTL



---
 rtl/des_ip_stage1_if.sv | 24 ++
 rtl/des_ip_stage1.sv | 89 ++++++++
 2 files changed

// File: rtl/des_ip_stage1_if.sv
// Handshake bundle between the DES input stage and its neighbours: 64-bit block in,
// L0/R0 halves plus mode out, and the current buffer occupancy.
interface des_ip_stage1_if;
  logic        in_valid;
  logic        in_ready;
  logic [64:1] data_in;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [32:1] data_l;
  logic [32:1] data_r;
  logic        out_mode;
  logic [1:0]  occupancy;

  modport master (
    output in_valid, data_in, in_mode, out_ready,
    input  in_ready, out_valid, data_l, data_r, out_mode, occupancy
  );

  modport slave (
    input  in_valid, data_in, in_mode, out_ready,
    output in_ready, out_valid, data_l, data_r, out_mode, occupancy
  );
endinterface

// File: rtl/des_ip_stage1.sv
// DES input stage: initial permutation of each accepted block, split into L0/R0,
// queued with its mode bit in a 2-entry FIFO whose head drives the outputs.
module des_ip_stage1 (
  input logic             clk,
  input logic             rst_n,
  des_ip_stage1_if.slave  bus
);

  // Source DES bit for each permuted bit 1..64 (bit 1 is the LSB of data_in).
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  typedef struct packed {
    logic [64:1] perm;
    logic        mode;
  } entry_t;

  logic [64:1] perm;
  entry_t      mem [2];
  entry_t      head;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        ready_q;
  logic        push;
  logic        pop;

  for (genvar i = 1; i <= 64; i++) begin : g_ip
    assign perm[i] = bus.data_in[IP_TAB[i-1]];
  end

  // ready_q is registered so in_ready never depends combinationally on out_ready.
  assign push = bus.in_valid && ready_q;
  assign pop  = (count != 2'd0) && bus.out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two storage entries are reset because the head entry drives the
      // outputs directly and must read as zero while reset is asserted.
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // pre-edge values, so push/pop in the same cycle see a consistent state.
      if (push) begin
        mem[wr_ptr] <= '{perm: perm, mode: bus.in_mode};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  // A push never targets the head slot while it is valid, so a stalled head holds.
  assign head          = mem[rd_ptr];
  assign bus.data_l    = head.perm[32:1];
  assign bus.data_r    = head.perm[64:33];
  assign bus.out_mode  = head.mode;
  assign bus.out_valid = (count != 2'd0);
  assign bus.occupancy = count;
  assign bus.in_ready  = ready_q;

endmodule
